ascii_code_streamer: RTL

// - Downstream of the string-to-ASCII divider: accepts one packed ASCII string of STR_LEN bytes,

---
 rtl/ascii_code_streamer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ascii_code_streamer.sv
// Accepts one packed ASCII string, maps each byte to a 6-bit symbol code and streams one code per beat.
// Optional build macro ASCII_SKIP_NUL_EN: NUL bytes are dropped instead of being emitted as 8'h3F.
module ascii_code_streamer #(
  parameter int STR_LEN = 4,
  parameter int IDX_W   = (STR_LEN > 1) ? $clog2(STR_LEN) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*STR_LEN-1:0] str_in,
  input  logic                 str_valid,
  output logic                 str_ready,
  output logic [7:0]           code_out,
  output logic                 code_valid,
  input  logic                 code_ready,
  output logic                 code_last,
  output logic [IDX_W-1:0]     code_index,
  output logic                 invalid_char,
  output logic                 done
);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  localparam logic [7:0] CODE_BAD = 8'h3F;

  state_t               state_p0, state_n;
  logic [8*STR_LEN-1:0] str_buf_p0;
  logic [IDX_W-1:0]     idx_p0;
  logic                 sticky_p0;
  logic                 done_p0;

  logic [IDX_W-1:0]     cur_pos;
  logic [7:0]           cur_char;
  logic [7:0]           cur_code;
  logic                 beat_avail;
  logic                 beat_last;
  logic                 capture;
  logic                 xfer;
  logic                 finish;

  // Case-folded letters, digits, space and period; everything else is the invalid marker.
  function automatic logic [7:0] map_char(input logic [7:0] c);
    logic [7:0] code;
    code = CODE_BAD;
    if (c >= 8'h41 && c <= 8'h5A) begin
      code = c - 8'h40;
    end else if (c >= 8'h61 && c <= 8'h7A) begin
      code = c - 8'h60;
    end else if (c >= 8'h30 && c <= 8'h39) begin
      code = c - 8'h15;
    end else if (c == 8'h20) begin
      code = 8'h00;
    end else if (c == 8'h2E) begin
      code = 8'h25;
    end
    return code;
  endfunction

  // Stage p0 -> beat selection: idx_p0 is the lowest position still eligible for emission.
  always_comb begin
    cur_pos    = idx_p0;
    cur_char   = 8'h00;
    beat_avail = 1'b1;
    beat_last  = (idx_p0 == IDX_W'(STR_LEN - 1));
`ifdef ASCII_SKIP_NUL_EN
    beat_avail = 1'b0;
    beat_last  = 1'b1;
    for (int i = STR_LEN - 1; i >= 0; i--) begin
      if (IDX_W'(i) >= idx_p0 && str_buf_p0[8*i +: 8] != 8'h00) begin
        cur_pos    = IDX_W'(i);
        beat_avail = 1'b1;
      end
    end
    for (int i = 0; i < STR_LEN; i++) begin
      if (IDX_W'(i) > cur_pos && str_buf_p0[8*i +: 8] != 8'h00) begin
        beat_last = 1'b0;
      end
    end
`endif
    for (int i = 0; i < STR_LEN; i++) begin
      if (IDX_W'(i) == cur_pos) begin
        cur_char = str_buf_p0[8*i +: 8];
      end
    end
    cur_code = map_char(cur_char);
  end

  always_comb begin
    state_n    = state_p0;
    str_ready  = 1'b0;
    code_valid = 1'b0;
    capture    = 1'b0;
    xfer       = 1'b0;
    finish     = 1'b0;
    case (state_p0)
      IDLE: begin
        str_ready = 1'b1;
        if (str_valid) begin
          capture = 1'b1;
          state_n = STREAM;
        end
      end
      STREAM: begin
        if (beat_avail) begin
          code_valid = 1'b1;
          if (code_ready) begin
            xfer = 1'b1;
            if (beat_last) begin
              finish  = 1'b1;
              state_n = IDLE;
            end
          end
        end else begin
          // Nothing left to emit (only reachable when NULs are skipped).
          finish  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0   <= IDLE;
      str_buf_p0 <= '0;
      idx_p0     <= '0;
      sticky_p0  <= 1'b0;
      done_p0    <= 1'b0;
    end else begin
      state_p0 <= state_n;
      done_p0  <= finish;
      if (capture) begin
        str_buf_p0 <= str_in;
        idx_p0     <= '0;
        sticky_p0  <= 1'b0;
      end else begin
        if (xfer && !beat_last) begin
          idx_p0 <= cur_pos + IDX_W'(1);
        end
        if (code_valid && cur_code == CODE_BAD) begin
          sticky_p0 <= 1'b1;
        end
      end
    end
  end

  // Outputs are quiet (zero) whenever no beat is presented.
  assign code_out     = code_valid ? cur_code : 8'h00;
  assign code_index   = code_valid ? cur_pos : '0;
  assign code_last    = code_valid && beat_last;
  assign invalid_char = sticky_p0 || (code_valid && cur_code == CODE_BAD);
  assign done         = done_p0;

endmodule
